// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared funct codes, FSM state encoding and opcode helpers
//               for the iterative HI/LO multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic is_arith(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_DIV);
    endfunction

    function automatic logic is_div_op(input logic [5:0] f);
        return (f == FN_DIV) || (f == FN_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration over the {hi, lo} work pair:
//               shift-add for multiply, restoring shift-subtract for divide.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        is_div,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic [31:0] opnd,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    logic [32:0] w_sum;
    logic [32:0] w_shifted;
    logic        w_fits;

    // Partial remainder is shifted before the compare, so it needs 33 bits.
    assign w_sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : 33'd0);
    assign w_shifted = {hi_in, lo_in[31]};
    assign w_fits    = (w_shifted >= {1'b0, opnd});

    always_comb begin
        hi_out = hi_in;
        lo_out = lo_in;
        if (is_div) begin
            if (w_fits) begin
                hi_out = w_shifted[31:0] - opnd;
                lo_out = {lo_in[30:0], 1'b1};
            end else begin
                hi_out = w_shifted[31:0];
                lo_out = {lo_in[30:0], 1'b0};
            end
        end else begin
            hi_out = w_sum[32:1];
            lo_out = {w_sum[0], lo_in[31:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : MIPS HI/LO multiply/divide controller: 32-cycle iterative
//               MULT/MULTU/DIV/DIVU plus single-cycle MTHI/MTLO writes.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  funccode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         op_q, op_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [31:0]        work_hi_q, work_hi_d, work_lo_q, work_lo_d;
    logic [31:0]        opnd_q, opnd_d;
    logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic               w_a_neg, w_b_neg;
    logic [31:0]        w_step_hi, w_step_lo;
    logic [63:0]        w_prod, w_prod_neg;

    assign w_a_neg    = is_signed_op(op_q) & a_q[31];
    assign w_b_neg    = is_signed_op(op_q) & b_q[31];
    assign w_prod     = {work_hi_q, work_lo_q};
    assign w_prod_neg = 64'd0 - w_prod;

    muldiv_step u_step (
        .is_div (is_div_op(op_q)),
        .hi_in  (work_hi_q),
        .lo_in  (work_lo_q),
        .opnd   (opnd_q),
        .hi_out (w_step_hi),
        .lo_out (w_step_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        opnd_d    = opnd_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        case (state_q)
            // DONE already shows busy=0, so a stalled CPU issues its next
            // request there; it is accepted exactly as in IDLE.
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    if (is_arith(funccode)) begin
                        state_d = ST_PREP;
                        busy_d  = 1'b1;
                        op_d    = funccode;
                        a_d     = a;
                        b_d     = b;
                    end else if (funccode == FN_MTHI) begin
                        hi_d = a;
                    end else if (funccode == FN_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_PREP: begin
                work_hi_d = 32'd0;
                work_lo_d = w_a_neg ? (32'd0 - a_q) : a_q;
                opnd_d    = w_b_neg ? (32'd0 - b_q) : b_q;
                neg_lo_d  = w_a_neg ^ w_b_neg;
                neg_hi_d  = w_a_neg;
                cnt_d     = '0;
                state_d   = ST_ITER;
            end
            ST_ITER: begin
                work_hi_d = w_step_hi;
                work_lo_d = w_step_lo;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (is_div_op(op_q)) begin
                    if (b_q == 32'd0) begin
                        lo_d  = 32'hFFFF_FFFF;
                        hi_d  = a_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = neg_lo_q ? (32'd0 - work_lo_q) : work_lo_q;
                        hi_d = neg_hi_q ? (32'd0 - work_hi_q) : work_hi_q;
                    end
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? w_prod_neg : w_prod;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= 6'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            work_hi_q <= 32'd0;
            work_lo_q <= 32'd0;
            opnd_q    <= 32'd0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            opnd_q    <= opnd_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Scoreboard bench for muldiv_ctrl: reference model results are
//               queued at issue and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam int         LATENCY = 35;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [5:0]  funccode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          idx;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   op_idx = 0;
    bit   mon_en = 1'b0;

    muldiv_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .funccode    (funccode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      p;
        logic [63:0] u;
        int          sx;
        int          sy;
        e.hi = 32'd0; e.lo = 32'd0; e.dbz = 1'b0; e.idx = 0;
        sx = x; sy = y;
        case (f)
            F_MULT: begin
                p = longint'(sx) * longint'(sy);
                {e.hi, e.lo} = p;
            end
            F_MULTU: begin
                u = {32'd0, x} * {32'd0, y};
                {e.hi, e.lo} = u;
            end
            F_DIV: begin
                if (y == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = x; e.dbz = 1'b1;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 32'd0;
                end else begin
                    e.lo = sx / sy; e.hi = sx % sy;
                end
            end
            F_DIVU: begin
                if (y == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = x; e.dbz = 1'b1;
                end else begin
                    e.lo = x / y; e.hi = x % y;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Result scoreboard and div_by_zero-outside-done watch
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (done === 1'b1) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done got done=1 hi=%h lo=%h, expected no done", hi, lo);
                end else begin
                    e = sb.pop_front();
                    if (hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz) begin
                        fails++;
                        $display("FAIL result[%0d] got hi=%h lo=%h dbz=%b expected hi=%h lo=%h dbz=%b",
                                 e.idx, hi, lo, div_by_zero, e.hi, e.lo, e.dbz);
                    end
                end
            end else begin
                tests++;
                if (div_by_zero !== 1'b0) begin
                    fails++;
                    $display("FAIL dbz_without_done got dbz=%b done=%b expected dbz=0", div_by_zero, done);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, input bit push);
        exp_t e;
        if (push) begin
            e = model(f, x, y);
            e.idx = op_idx;
            op_idx++;
            sb.push_back(e);
        end
        start = 1'b1; funccode = f; a = x; b = y;
        @(negedge clk);
        start = 1'b0; funccode = 6'd0; a = 32'd0; b = 32'd0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 1;
        while (done !== 1'b1 && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; funccode = 6'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b expected=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b expected=0", done); end
        tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz got=%b expected=0", div_by_zero); end
        tests++; if (hi !== 32'd0) begin fails++; $display("FAIL reset_hi got=%h expected=0", hi); end
        tests++; if (lo !== 32'd0) begin fails++; $display("FAIL reset_lo got=%h expected=0", lo); end
        issue(F_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
        tests++; if (hi !== 32'd0) begin fails++; $display("FAIL reset_priority_hi got=%h expected=0", hi); end
        issue(F_MULT, 32'd3, 32'd5, 1'b0);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_priority_busy got=%b expected=0", busy); end
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [5:0]  fv[5] = '{F_MULTU, F_MULT, F_DIV, F_DIVU, F_DIV};
        logic [31:0] av[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [31:0] bv[5] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
        int cycles;
        for (int i = 0; i < 5; i++) begin
            issue(fv[i], av[i], bv[i], 1'b1);
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL directed_busy[%0d] got=%b expected=1", i, busy); end
            wait_done(cycles);
            tests++; if (cycles != LATENCY) begin fails++; $display("FAIL directed_latency[%0d] got=%0d expected=%0d", i, cycles, LATENCY); end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL directed_busy_done[%0d] got=%b expected=0", i, busy); end
            @(negedge clk);
        end
    endtask

    task automatic test_hold_hilo();
        int cycles;
        issue(F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        wait_done(cycles);
        @(negedge clk);
        issue(F_DIV, 32'd100, 32'd9, 1'b1);
        cycles = 1;
        while (done !== 1'b1 && cycles < 60) begin
            if (cycles == 34) begin
                tests++;
                if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
                    fails++;
                    $display("FAIL hold_hilo got hi=%h lo=%h expected hi=ffffffff lo=ffffffeb", hi, lo);
                end
            end
            @(negedge clk);
            cycles++;
        end
        tests++; if (cycles != LATENCY) begin fails++; $display("FAIL hold_latency got=%0d expected=%0d", cycles, LATENCY); end
        @(negedge clk);
    endtask

    task automatic test_move();
        issue(F_MTHI, 32'hA5A5_A5A5, 32'd0, 1'b0);
        tests++; if (hi !== 32'hA5A5_A5A5) begin fails++; $display("FAIL mthi got=%h expected=a5a5a5a5", hi); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi_busy got=%b expected=0", busy); end
        issue(F_MTLO, 32'h5A5A_0F0F, 32'd0, 1'b0);
        tests++; if (lo !== 32'h5A5A_0F0F || hi !== 32'hA5A5_A5A5) begin
            fails++; $display("FAIL mtlo got hi=%h lo=%h expected hi=a5a5a5a5 lo=5a5a0f0f", hi, lo);
        end
        issue(6'h20, 32'h1111_2222, 32'h3, 1'b0);
        tests++; if (hi !== 32'hA5A5_A5A5 || lo !== 32'h5A5A_0F0F || busy !== 1'b0) begin
            fails++; $display("FAIL ignored_funct got hi=%h lo=%h busy=%b expected hi=a5a5a5a5 lo=5a5a0f0f busy=0", hi, lo, busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int cycles;
        int busy_low;
        issue(F_MULT, 32'h0001_2345, 32'hFFFF_0001, 1'b1);
        cycles = 1; busy_low = 0;
        while (done !== 1'b1 && cycles < 60) begin
            if (cycles == 9) begin
                start = 1'b1; funccode = F_DIV; a = 32'd1000; b = 32'd3;
            end else begin
                start = 1'b0; funccode = 6'd0; a = 32'd0; b = 32'd0;
            end
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        tests++; if (cycles != LATENCY) begin fails++; $display("FAIL ignore_latency got=%0d expected=%0d", cycles, LATENCY); end
        tests++; if (busy_low != 0) begin fails++; $display("FAIL ignore_busy got %0d low cycles expected 0", busy_low); end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int done_seen;
        issue(F_DIVU, 32'h89AB_CDEF, 32'd17, 1'b1);
        repeat (18) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        sb.delete();
        reset_n = 1'b1;
        tests++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++; $display("FAIL reset_mid got busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0", busy, hi, lo);
        end
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) done_seen++;
        end
        tests++; if (done_seen != 0) begin fails++; $display("FAIL reset_mid_done got %0d done cycles expected 0", done_seen); end
        issue(F_MTLO, 32'h0000_1234, 32'd0, 1'b0);
        tests++; if (lo !== 32'h0000_1234 || done !== 1'b0) begin
            fails++; $display("FAIL reset_mid_mtlo got lo=%h done=%b expected lo=00001234 done=0", lo, done);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cycles;
        issue(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        wait_done(cycles);
        tests++; if (cycles != LATENCY) begin fails++; $display("FAIL b2b_first_latency got=%0d expected=%0d", cycles, LATENCY); end
        issue(F_DIVU, 32'hFFFF_FFFF, 32'd10, 1'b1);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept_busy got=%b expected=1", busy); end
        wait_done(cycles);
        tests++; if (cycles != LATENCY) begin fails++; $display("FAIL b2b_second_latency got=%0d expected=%0d", cycles, LATENCY); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [5:0]  ops[4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        logic [31:0] x;
        logic [31:0] y;
        int          cycles;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 200; n++) begin
                x = $urandom;
                y = $urandom;
                if ($urandom_range(0, 7) == 0) y = $urandom_range(1, 255);
                if ($urandom_range(0, 15) == 0) y = 32'd0;
                if ($urandom_range(0, 31) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                issue(ops[k], x, y, 1'b1);
                wait_done(cycles);
                tests++;
                if (cycles != LATENCY) begin
                    fails++;
                    $display("FAIL random_latency[%0d] got=%0d expected=%0d", op_idx - 1, cycles, LATENCY);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_hilo();
        test_move();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (5) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL pending_results got %0d outstanding expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
